// File: rtl/wb_fabric_bridge_if.sv
// Wishbone B4 classic bus bundle between the management SoC (master) and the fabric bridge (slave).
// Signal names keep the SoC-side Wishbone convention so they line up with user_project_wrapper.
interface wb_fabric_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/wb_fabric_bridge.sv
// Wishbone classic slave exposing CTRL/STATUS/SCRATCH registers, a TX FIFO toward the fabric
// and a single-entry RX holding register from the fabric.
module wb_fabric_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TX_DEPTH  = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_fabric_bridge_if.slave   wb,
  output logic [7:0]          ctrl_o,
  output logic [31:0]         tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [31:0]         rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o
);

  localparam int            AW       = $clog2(TX_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(TX_DEPTH);

  localparam logic [5:0] OFF_CTRL    = 6'd0;
  localparam logic [5:0] OFF_STATUS  = 6'd1;
  localparam logic [5:0] OFF_TXDATA  = 6'd2;
  localparam logic [5:0] OFF_RXDATA  = 6'd3;
  localparam logic [5:0] OFF_SCRATCH = 6'd4;

  logic [7:0]    ctrl_q;
  logic [31:0]   scratch_q;
  logic [31:0]   tx_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   tx_cnt;
  logic [31:0]   rx_hold;
  logic          rx_valid_q;
  logic          tx_ovf;
  logic          rx_unf;

  logic        hit;
  logic        req;
  logic        wr_req;
  logic        rd_req;
  logic [5:0]  off;
  logic        tx_empty;
  logic        tx_full;
  logic        tx_pop;
  logic        push_req;
  logic        push_ok;
  logic        ovf_set;
  logic        rx_cap;
  logic        rx_rd;
  logic        unf_set;
  logic        w1c;
  logic [2:0]  level;
  logic [31:0] status;
  logic [31:0] rdata;

  // Both fabric streams use valid/ready: a beat transfers on the rising edge where valid and
  // ready are both high; valid never depends on ready, and data is stable while valid is high.
  assign hit      = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign req      = wb.wbs_stb_i & wb.wbs_cyc_i & hit & ~wb.wbs_ack_o;
  assign wr_req   = req & wb.wbs_we_i;
  assign rd_req   = req & ~wb.wbs_we_i;
  assign off      = wb.wbs_adr_i[7:2];

  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == CNT_FULL;
  assign tx_pop   = tx_valid_o & tx_ready_i;
  assign push_req = wr_req & (off == OFF_TXDATA);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req & (~tx_full | tx_pop);
  assign ovf_set  = push_req & tx_full & ~tx_pop;

  assign rx_cap   = rx_valid_i & rx_ready_o;
  assign rx_rd    = rd_req & (off == OFF_RXDATA);
  assign unf_set  = rx_rd & ~rx_valid_q;
  assign w1c      = wr_req & (off == OFF_STATUS) & wb.wbs_sel_i[1];

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_empty ? 32'h0 : tx_mem[rd_ptr];
  assign rx_ready_o = ~rx_valid_q;
  assign ctrl_o     = ctrl_q;

  always_comb begin
    level  = 3'(tx_cnt);
    status = {21'h0, rx_unf, tx_ovf, rx_valid_q, 1'b0, level, 2'b00, tx_full, tx_empty};
    rdata  = 32'h0;
    case (off)
      OFF_CTRL:    rdata = {24'h0, ctrl_q};
      OFF_STATUS:  rdata = status;
      OFF_RXDATA:  rdata = rx_valid_q ? rx_hold : 32'h0;
      OFF_SCRATCH: rdata = scratch_q;
      default:     rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= 32'h0;
      ctrl_q       <= 8'h0;
      scratch_q    <= 32'h0;
    end else begin
      wb.wbs_ack_o <= req;
      wb.wbs_dat_o <= rd_req ? rdata : 32'h0;
      if (wr_req && off == OFF_CTRL && wb.wbs_sel_i[0]) ctrl_q <= wb.wbs_dat_i[7:0];
      if (wr_req && off == OFF_SCRATCH) begin
        for (int b = 0; b < 4; b++) begin
          if (wb.wbs_sel_i[b]) scratch_q[8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // Storage needs no reset: tx_data_o is gated while the FIFO is empty.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) tx_mem[wr_ptr] <= wb.wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_hold    <= 32'h0;
      rx_valid_q <= 1'b0;
      tx_ovf     <= 1'b0;
      rx_unf     <= 1'b0;
    end else begin
      if (rx_cap) begin
        rx_hold    <= rx_data_i;
        rx_valid_q <= 1'b1;
      end else if (rx_rd) begin
        rx_valid_q <= 1'b0;
      end
      // A new sticky event beats a same-cycle write-1-to-clear.
      tx_ovf <= ovf_set | (tx_ovf & ~(w1c & wb.wbs_dat_i[9]));
      rx_unf <= unf_set | (rx_unf & ~(w1c & wb.wbs_dat_i[10]));
    end
  end

endmodule

// File: tb/tb_wb_fabric_bridge.sv
// Directed bench for wb_fabric_bridge: bus driver tasks push expected read data into a queue,
// and a negedge monitor pops and compares on every acknowledge.
module tb_wb_fabric_bridge;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_TX   = BASE + 32'h08;
  localparam logic [31:0] A_RX   = BASE + 32'h0C;
  localparam logic [31:0] A_SCR  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ctrl;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = 32'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int errors = 0;
  int checks = 0;
  // {is_read, address, expected read data}
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic        prev_ack = 1'b0;

  always #5 clk = ~clk;

  wb_fabric_bridge_if bus ();

  wb_fabric_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (bus),
    .ctrl_o     (ctrl),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.wbs_ack_o === 1'b1) begin
      check("ack_single_cycle", {31'h0, prev_ack}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack seen with no transaction outstanding (adr %h)", bus.wbs_adr_i);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[64]) begin
          checks++;
          if (bus.wbs_dat_o !== mon_e[31:0]) begin
            errors++;
            $display("FAIL read_data @%h: got %h, expected %h", mon_e[63:32], bus.wbs_dat_o, mon_e[31:0]);
          end
        end
      end
    end else begin
      check("dat_o_zero_without_ack", bus.wbs_dat_o, 32'h0);
    end
    prev_ack = (bus.wbs_ack_o === 1'b1);
  end

  // Caller is at a negedge; returns at the negedge where ack is seen.
  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp_rd);
    int n;
    if (bus.wbs_ack_o === 1'b1) @(negedge clk);
    exp_q.push_back({~we, adr, exp_rd});
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (bus.wbs_ack_o !== 1'b1 && n < 100);
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    check("ack_latency", n, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_cycle(adr, 1'b1, dat, sel, 32'h0);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp);
    wb_cycle(adr, 1'b0, 32'h0, 4'hF, exp);
  endtask

  task automatic no_ack(input logic [31:0] adr);
    int acks;
    if (bus.wbs_ack_o === 1'b1) @(negedge clk);
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    check("foreign_addr_no_ack", acks, 32'd0);
  endtask

  task automatic drain_expect(input logic [31:0] v0, input logic [31:0] v1,
                              input logic [31:0] v2, input logic [31:0] v3);
    logic [31:0] vals [4];
    vals = '{v0, v1, v2, v3};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tx_valid_during_drain", {31'h0, tx_valid}, 32'h1);
      check("tx_data_order", tx_data, vals[i]);
      @(negedge clk);
    end
    check("tx_valid_after_drain", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
  endtask

  initial begin
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("reset_ctrl", {24'h0, ctrl}, 32'h0);
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset_tx_data", tx_data, 32'h0);
    check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    wb_read(A_STAT, 32'h0000_0001);
    wb_read(A_SCR, 32'h0);

    wb_write(A_CTRL, 32'h55, 4'hF);
    check("ctrl_after_write", {24'h0, ctrl}, 32'h55);
    wb_read(A_CTRL, 32'h0000_0055);
    wb_write(A_CTRL, 32'hAA, 4'hE);
    check("ctrl_sel0_low", {24'h0, ctrl}, 32'h55);
    wb_read(BASE + 32'h3, 32'h0000_0055);

    wb_write(A_SCR, 32'hFFFF_FFFF, 4'hF);
    wb_write(A_SCR, 32'hAABB_CCDD, 4'h3);
    wb_read(A_SCR, 32'hFFFF_CCDD);

    wb_read(BASE + 32'h20, 32'h0);
    wb_write(A_RX, 32'hDEAD_BEEF, 4'hF);
    wb_read(A_TX, 32'h0);

    for (int i = 1; i <= 5; i++) wb_write(A_TX, i, 4'h0);
    wb_read(A_STAT, 32'h0000_0242);
    drain_expect(32'd1, 32'd2, 32'd3, 32'd4);
    wb_write(A_STAT, 32'h0000_0200, 4'hF);
    wb_read(A_STAT, 32'h0000_0001);

    // Push into a full FIFO in the same cycle as a pop: accepted, no overflow.
    for (int i = 1; i <= 4; i++) wb_write(A_TX, 32'h10 + i, 4'hF);
    @(negedge clk);
    tx_ready = 1'b1;
    wb_write(A_TX, 32'h0000_000A, 4'hF);
    tx_ready = 1'b0;
    wb_read(A_STAT, 32'h0000_0042);
    drain_expect(32'h12, 32'h13, 32'h14, 32'h0A);

    rx_data  = 32'h1234_5678;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("rx_ready_low_after_capture", {31'h0, rx_ready}, 32'h0);
    rx_data  = 32'hFFFF_0000;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    wb_read(A_STAT, 32'h0000_0101);
    wb_read(A_RX, 32'h1234_5678);
    check("rx_ready_after_read", {31'h0, rx_ready}, 32'h1);
    wb_read(A_RX, 32'h0);
    wb_read(A_STAT, 32'h0000_0401);
    wb_write(A_STAT, 32'h0000_0400, 4'h1);
    wb_read(A_STAT, 32'h0000_0401);
    wb_write(A_STAT, 32'h0000_0600, 4'hF);
    wb_read(A_STAT, 32'h0000_0001);

    no_ack(BASE + 32'h100);
    no_ack(32'h2000_0000);

    // Reset lands while a request is being acknowledged with two words queued.
    wb_write(A_TX, 32'h77, 4'hF);
    wb_write(A_TX, 32'h78, 4'hF);
    wb_read(A_STAT, 32'h0000_0020);
    @(negedge clk);
    bus.wbs_adr_i = A_CTRL;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_dat_i = 32'h99;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    check("ack_before_reset", {31'h0, bus.wbs_ack_o}, 32'h1);
    exp_q.push_back({1'b0, A_CTRL, 32'h0});
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("mid_reset_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("mid_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("mid_reset_ctrl", {24'h0, ctrl}, 32'h0);
    check("mid_reset_rx_ready", {31'h0, rx_ready}, 32'h1);
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_read(A_STAT, 32'h0000_0001);
    wb_read(A_CTRL, 32'h0);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
